// File: rtl/compute_ctrl_decoder_pkg.sv
// Shared definitions for the host control-word decoder: command codes, FSM
// states, status bit positions and control_low_word field offsets.
package compute_ctrl_pkg;

  // Raw command values carried in control_high_word
  localparam logic [31:0] CMD_RESET = 32'd0;
  localparam logic [31:0] CMD_HOST  = 32'd1;
  localparam logic [31:0] CMD_EXEC  = 32'd2;

  // Decoded command; unknown codes collapse onto host access
  typedef enum logic [1:0] {
    C_RESET = 2'd0,
    C_HOST  = 2'd1,
    C_EXEC  = 2'd2
  } cmd_t;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_HOST  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Status word bit positions
  localparam int ST_DONE_BIT = 0;
  localparam int ST_BUSY_BIT = 1;
  localparam int ST_ERR_BIT  = 2;
  localparam int ST_HOST_BIT = 3;
  localparam int ST_CYC_LSB  = 16;

  // control_low_word field offsets
  localparam int CTL_ADDR_LSB = 0;
  localparam int CTL_WEA_BIT  = 10;
  localparam int CTL_SEL_BIT  = 11;

  function automatic cmd_t decode_cmd(input logic [31:0] word);
    cmd_t c;
    case (word)
      CMD_RESET: c = C_RESET;
      CMD_EXEC:  c = C_EXEC;
      CMD_HOST:  c = C_HOST;
      default:   c = C_HOST;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/compute_ctrl_decoder_run_cycle_counter.sv
// Saturating run-cycle counter: clear wins, enable counts up, otherwise frozen.
module run_cycle_counter #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count
);

  logic [CYC_W-1:0] count_r;

  // Count run cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CYC_W{1'b0}};
    end else if (clr) begin
      count_r <= {CYC_W{1'b0}};
    end else if (en && (count_r != {CYC_W{1'b1}})) begin
      count_r <= count_r + {{(CYC_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/compute_ctrl_decoder.sv
// Responder for the host control-word protocol: turns the control/data words
// into RAM write strobes, a one-shot core start, read-back data and status.
module compute_ctrl_decoder
  import compute_ctrl_pkg::*;
#(
  parameter int DADDR_W = 10,
  parameter int PADDR_W = 6,
  parameter int INSTR_W = 37,
  parameter int CYC_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        control_low_word,
  input  logic [31:0]        control_high_word,
  input  logic [31:0]        dina_ext_low_word,
  input  logic [31:0]        dina_ext_high_word,
  output logic [31:0]        dout_ext_low_word,
  output logic [31:0]        dout_ext_high_word,
  output logic [31:0]        status,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [63:0]        dmem_din,
  input  logic [63:0]        dmem_dout,
  output logic [PADDR_W-1:0] pmem_addr,
  output logic               pmem_we,
  output logic [INSTR_W-1:0] pmem_din,
  output logic               core_rst,
  output logic               core_start,
  input  logic               core_done,
  output logic               host_sel
);

  state_t             state_r, state_nxt_s;
  cmd_t               cmd_s;
  logic [DADDR_W-1:0] addr_s;
  logic               wea_s, sel_s, host_ok_s, pmem_ok_s, err_set_s;
  logic [63:0]        dina_s, dout_r;
  logic               core_rst_r, core_start_r, host_sel_r, busy_r, done_r, err_r;
  logic               rd_pend_r, rd_sel_r;
  logic [CYC_W-1:0]   count_s;
  logic               unused_ctl_s;

  assign cmd_s        = decode_cmd(control_high_word);
  assign addr_s       = control_low_word[CTL_ADDR_LSB +: DADDR_W];
  assign wea_s        = control_low_word[CTL_WEA_BIT];
  assign sel_s        = control_low_word[CTL_SEL_BIT];
  assign unused_ctl_s = ^control_low_word[31:12];
  assign dina_s       = {dina_ext_high_word, dina_ext_low_word};

  // Host owns the RAM ports except during the start cycle and while running
  assign host_ok_s = host_sel_r && (state_r != S_START);
  assign pmem_ok_s = (addr_s[DADDR_W-1:PADDR_W] == {(DADDR_W-PADDR_W){1'b0}});
  // Writes to a missing program slot, or while the core owns the RAMs, are errors
  assign err_set_s = wea_s && (!host_ok_s || (sel_s && !pmem_ok_s));

  assign dmem_we   = host_ok_s && wea_s && !sel_s;
  assign dmem_addr = addr_s;
  assign dmem_din  = dina_s;
  assign pmem_we   = host_ok_s && wea_s && sel_s && pmem_ok_s;
  assign pmem_addr = addr_s[PADDR_W-1:0];
  assign pmem_din  = dina_s[INSTR_W-1:0];

  // Next-state decode; abort (cmd 0) outranks core_done while running
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_RESET: begin
        if (cmd_s == C_HOST)      state_nxt_s = S_HOST;
        else if (cmd_s == C_EXEC) state_nxt_s = S_START;
        else                      state_nxt_s = S_RESET;
      end
      S_HOST: begin
        if (cmd_s == C_RESET)     state_nxt_s = S_RESET;
        else if (cmd_s == C_EXEC) state_nxt_s = S_START;
        else                      state_nxt_s = S_HOST;
      end
      S_START: state_nxt_s = S_RUN;
      S_RUN: begin
        if (cmd_s == C_RESET)     state_nxt_s = S_RESET;
        else if (core_done)       state_nxt_s = S_DONE;
        else                      state_nxt_s = S_RUN;
      end
      S_DONE: begin
        if (cmd_s == C_RESET)     state_nxt_s = S_RESET;
        else if (cmd_s == C_HOST) state_nxt_s = S_HOST;
        else                      state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_RESET;
    endcase
  end

  // FSM state plus registered control outputs and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_RESET;
      core_rst_r   <= 1'b1;
      host_sel_r   <= 1'b1;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      core_rst_r   <= (state_nxt_s == S_RESET);
      host_sel_r   <= (state_nxt_s == S_RESET) || (state_nxt_s == S_HOST) ||
                      (state_nxt_s == S_DONE);
      core_start_r <= (state_nxt_s == S_START);
      busy_r       <= (state_nxt_s == S_RUN);
      done_r       <= (state_nxt_s == S_DONE);
      if ((state_nxt_s == S_RESET) && (state_r != S_RESET)) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Read-back: request at N, RAM data at N+1, captured into dout at N+2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_r <= 1'b0;
      rd_sel_r  <= 1'b0;
      dout_r    <= 64'd0;
    end else begin
      rd_pend_r <= host_ok_s && !wea_s;
      rd_sel_r  <= sel_s;
      if (rd_pend_r) begin
        dout_r <= rd_sel_r ? 64'd0 : dmem_dout;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  run_cycle_counter #(.CYC_W(CYC_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_r == S_START),
    .en    (state_r == S_RUN),
    .count (count_s)
  );

  assign dout_ext_low_word  = dout_r[31:0];
  assign dout_ext_high_word = dout_r[63:32];
  assign core_rst           = core_rst_r;
  assign core_start         = core_start_r;
  assign host_sel           = host_sel_r;
  assign status             = {count_s, 12'd0, host_sel_r, err_r, busy_r, done_r};

endmodule

// File: tb/tb_compute_ctrl_decoder.sv
// Scoreboard bench for compute_ctrl_decoder: the driver pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_compute_ctrl_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] control_low_word = 32'd0, control_high_word = 32'd0;
  logic [31:0] dina_ext_low_word = 32'd0, dina_ext_high_word = 32'd0;
  logic [31:0] dout_ext_low_word, dout_ext_high_word, status;
  logic [9:0]  dmem_addr;
  logic        dmem_we, pmem_we, core_rst, core_start, core_done, host_sel;
  logic [63:0] dmem_din, dmem_dout;
  logic [5:0]  pmem_addr;
  logic [36:0] pmem_din;

  compute_ctrl_decoder dut (
    .clk(clk), .rst(rst),
    .control_low_word(control_low_word), .control_high_word(control_high_word),
    .dina_ext_low_word(dina_ext_low_word), .dina_ext_high_word(dina_ext_high_word),
    .dout_ext_low_word(dout_ext_low_word), .dout_ext_high_word(dout_ext_high_word),
    .status(status), .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout), .pmem_addr(pmem_addr), .pmem_we(pmem_we),
    .pmem_din(pmem_din), .core_rst(core_rst), .core_start(core_start),
    .core_done(core_done), .host_sel(host_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data RAM model with 1-cycle synchronous read
  logic [63:0] mem [0:1023];
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_din;
    dmem_dout <= mem[dmem_addr];
  end

  // Core model: done level rises on the 20th run cycle after start
  int   ccnt = 0;
  logic crun = 1'b0;
  logic core_done_en = 1'b1;
  always @(posedge clk) begin
    if (rst || core_rst) begin
      crun <= 1'b0; ccnt <= 0;
    end else if (core_start) begin
      crun <= 1'b1; ccnt <= 0;
    end else if (crun) begin
      ccnt <= ccnt + 1;
    end
  end
  assign core_done = core_done_en && crun && (ccnt >= 19);

  typedef struct { int due; logic [9:0] addr; logic [63:0] data; } ev_t;
  ev_t wr_q[$], pw_q[$], rd_q[$];
  int  start_q[$];
  ev_t me;
  int  n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive(input logic [31:0] cmd, input logic [9:0] addr, input logic wea,
                       input logic sel, input logic [63:0] data);
    @(posedge clk);
    #1;
    control_high_word  = cmd;
    control_low_word   = {20'd0, sel, wea, addr};
    dina_ext_high_word = data[63:32];
    dina_ext_low_word  = data[31:0];
  endtask

  // Monitor: compares every strobe, start pulse and due read against the queues
  always @(negedge clk) begin
    if (dmem_we) begin
      if (wr_q.size() == 0) check("dmem_we_unexpected", {63'd0, dmem_we}, 64'd0);
      else begin
        me = wr_q.pop_front();
        check("dmem_we_cycle", 64'(cyc), 64'(me.due));
        check("dmem_addr", 64'(dmem_addr), 64'(me.addr));
        check("dmem_din", dmem_din, me.data);
      end
    end
    if (pmem_we) begin
      if (pw_q.size() == 0) check("pmem_we_unexpected", {63'd0, pmem_we}, 64'd0);
      else begin
        me = pw_q.pop_front();
        check("pmem_we_cycle", 64'(cyc), 64'(me.due));
        check("pmem_addr", 64'(pmem_addr), 64'(me.addr));
        check("pmem_din", 64'(pmem_din), me.data);
      end
    end
    if (core_start) begin
      if (start_q.size() == 0) check("core_start_unexpected", {63'd0, core_start}, 64'd0);
      else check("core_start_cycle", 64'(cyc), 64'(start_q.pop_front()));
    end
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      me = rd_q.pop_front();
      check("dout_ext", {dout_ext_high_word, dout_ext_low_word}, me.data);
    end
  end

  int busy_cnt;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_host_sel", 64'(host_sel), 64'd1);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_status", 64'(status), 64'h8);
    check("rst_dout", {dout_ext_high_word, dout_ext_low_word}, 64'd0);
    check("rst_we", {62'd0, dmem_we, pmem_we}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Data RAM write and 2-cycle read-back
    drive(32'd1, 10'd0, 1'b0, 1'b0, 64'd0);
    drive(32'd1, 10'd0, 1'b1, 1'b0, 64'hdb0cb67a17a9aeeb);
    wr_q.push_back('{cyc, 10'd0, 64'hdb0cb67a17a9aeeb});
    drive(32'd1, 10'd0, 1'b0, 1'b0, 64'd0);
    rd_q.push_back('{cyc + 2, 10'd0, 64'hdb0cb67a17a9aeeb});
    drive(32'd1, 10'd1023, 1'b1, 1'b0, 64'h0123456789abcdef);
    wr_q.push_back('{cyc, 10'd1023, 64'h0123456789abcdef});
    drive(32'd1, 10'd1023, 1'b0, 1'b0, 64'd0);
    rd_q.push_back('{cyc + 2, 10'd0, 64'h0123456789abcdef});
    drive(32'd1, 10'd1023, 1'b0, 1'b1, 64'd0);
    rd_q.push_back('{cyc + 2, 10'd0, 64'd0});
    repeat (3) drive(32'd1, 10'd0, 1'b0, 1'b0, 64'd0);

    // Program RAM writes: last valid slot, then first out-of-range address
    drive(32'd1, 10'd8, 1'b1, 1'b1, {32'h8, 32'h0});
    pw_q.push_back('{cyc, 10'd8, 64'h0800000000});
    drive(32'd1, 10'd63, 1'b1, 1'b1, {32'h1f, 32'hffffffff});
    pw_q.push_back('{cyc, 10'd63, 64'h1fffffffff});
    drive(32'd1, 10'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("status_no_err", 64'(status), 64'h8);
    drive(32'd1, 10'd64, 1'b1, 1'b1, {32'h8, 32'h0});
    drive(32'd1, 10'd70, 1'b1, 1'b1, {32'h8, 32'h0});
    drive(32'd1, 10'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("status_pmem_err", 64'(status), 64'hC);
    drive(32'd0, 10'd0, 1'b0, 1'b0, 64'd0);
    drive(32'd0, 10'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("status_err_cleared", 64'(status), 64'h8);
    check("core_rst_after_cmd0", 64'(core_rst), 64'd1);

    // Execute with cmd 2 held; write in the same cycle lands before start
    drive(32'd1, 10'd0, 1'b0, 1'b0, 64'd0);
    drive(32'd2, 10'd5, 1'b1, 1'b0, 64'hcafef00ddeadbeef);
    wr_q.push_back('{cyc, 10'd5, 64'hcafef00ddeadbeef});
    start_q.push_back(cyc + 1);
    busy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      drive(32'd2, 10'd0, 1'b0, 1'b0, 64'd0);
      @(negedge clk);
      if (status[1]) busy_cnt++;
    end
    check("busy_cycles", 64'(busy_cnt), 64'd20);
    check("status_done", 64'(status), 64'h0014_0009);
    check("host_sel_done", 64'(host_sel), 64'd1);
    drive(32'd2, 10'd5, 1'b0, 1'b0, 64'd0);
    rd_q.push_back('{cyc + 2, 10'd5, 64'hcafef00ddeadbeef});
    repeat (3) drive(32'd2, 10'd5, 1'b0, 1'b0, 64'd0);

    // Leave DONE, restart, attempt a write while running, then abort
    drive(32'd1, 10'd0, 1'b0, 1'b0, 64'd0);
    drive(32'd1, 10'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("status_host_after_done", 64'(status), 64'h0014_0008);
    drive(32'd2, 10'd0, 1'b0, 1'b0, 64'd0);
    start_q.push_back(cyc + 1);
    drive(32'd2, 10'd0, 1'b0, 1'b0, 64'd0);
    drive(32'd2, 10'd0, 1'b0, 1'b0, 64'd0);
    drive(32'd2, 10'd7, 1'b1, 1'b0, 64'd1);
    @(negedge clk);
    check("dmem_we_in_run", 64'(dmem_we), 64'd0);
    drive(32'd2, 10'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("status_run_err", 64'(status), 64'h0002_0006);
    drive(32'd0, 10'd0, 1'b0, 1'b0, 64'd0);
    drive(32'd0, 10'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("status_abort", 64'(status), 64'h0004_0008);
    check("core_rst_abort", 64'(core_rst), 64'd1);

    // Asynchronous reset in the middle of a run
    drive(32'd2, 10'd0, 1'b0, 1'b0, 64'd0);
    start_q.push_back(cyc + 1);
    repeat (4) drive(32'd2, 10'd0, 1'b0, 1'b0, 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    control_high_word = 32'd0;
    #1;
    check("async_core_rst", 64'(core_rst), 64'd1);
    check("async_host_sel", 64'(host_sel), 64'd1);
    check("async_core_start", 64'(core_start), 64'd0);
    check("async_status", 64'(status), 64'h8);
    check("async_dout", {dout_ext_high_word, dout_ext_low_word}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Long run without done: counter must saturate
    core_done_en = 1'b0;
    drive(32'd2, 10'd0, 1'b0, 1'b0, 64'd0);
    start_q.push_back(cyc + 1);
    repeat (1001) @(posedge clk);
    @(negedge clk);
    check("cycle_count_999", 64'(status[31:16]), 64'd999);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("cycle_count_sat", 64'(status[31:16]), 64'hFFFF);
    check("busy_long_run", 64'(status[1:0]), 64'd2);
    drive(32'd0, 10'd0, 1'b0, 1'b0, 64'd0);
    drive(32'd0, 10'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("status_final_idle", 64'(status[2:0]), 64'd0);

    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("pw_q_drained", 64'(pw_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("start_q_drained", 64'(start_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
